// File: rtl/fetch_buffer_pkg.sv
// Shared widths, the DLX NOP encoding and the fetch entry record for the fetch buffer.
// Combinational constants only.
package fetch_buffer_pkg;

   localparam int FB_PC_W    = 30;
   localparam int FB_INSTR_W = 32;
   localparam int FB_ENTRY_W = FB_PC_W + FB_INSTR_W;

   // DLX NOP: opcode 0x15 in bits [31:26], all other fields zero.
   localparam logic [FB_INSTR_W-1:0] FB_NOP_INSTR = 32'h5400_0000;

   typedef struct packed {
      logic [FB_PC_W-1:0]    pc;
      logic [FB_INSTR_W-1:0] instr;
   } fb_entry_t;

   function automatic fb_entry_t fb_make_entry(input logic [FB_PC_W-1:0]    pc,
                                               input logic [FB_INSTR_W-1:0] instr);
      fb_entry_t e;
      e.pc    = pc;
      e.instr = instr;
      return e;
   endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port.
// Contents are not reset; the owner tracks which slots hold live data.
module fetch_buffer_mem #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 62,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en_i,
   input  logic [PTR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic [PTR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0] rd_dat_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_buffer.sv
// In-order {PC, instruction} queue between fetch and decode; single-cycle flush of wrong-path entries.
// Latency 1 cycle (no fall-through); in_ready depends only on occupancy, so a full buffer stalls fetch.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int                   DEPTH     = 2,
   parameter int                   PC_W      = FB_PC_W,
   parameter int                   INSTR_W   = FB_INSTR_W,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = FB_NOP_INSTR,
   parameter int                   PTR_W     = $clog2(DEPTH),
   parameter int                   CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               flush,
   output logic               out_valid,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    out_link,
   output logic [INSTR_W-1:0] out_instr,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   count
);

   localparam int ENTRY_W = PC_W + INSTR_W;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [PC_W-1:0]    last_pc_q;

   logic               push;
   logic               pop;
   logic               mem_we;
   logic [ENTRY_W-1:0] wr_dat;
   logic [ENTRY_W-1:0] rd_dat;
   logic [PC_W-1:0]    head_pc;
   logic [INSTR_W-1:0] head_instr;

   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign mem_we    = push & ~flush;
   assign wr_dat    = {in_pc, in_instr};

   fetch_buffer_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (mem_we),
      .wr_addr_i (wr_ptr_q),
      .wr_dat_i  (wr_dat),
      .rd_addr_i (rd_ptr_q),
      .rd_dat_o  (rd_dat)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // Discard everything; a same-cycle push or pop has no effect on the queue.
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         last_pc_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         last_pc_q <= out_pc;
      end
   end

   assign head_pc    = rd_dat[ENTRY_W-1 -: PC_W];
   assign head_instr = rd_dat[INSTR_W-1:0];

   // While empty, keep showing the PC decode last saw; stale storage never reaches the ports.
   assign out_pc    = out_valid ? head_pc    : last_pc_q;
   assign out_instr = out_valid ? head_instr : NOP_INSTR;
   assign out_link  = out_pc + PC_W'(1);
   assign count     = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed vector bench for fetch_buffer: table of {inputs, expected outputs} plus async-reset sequence.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int PC_W    = FB_PC_W;
   localparam int INSTR_W = FB_INSTR_W;
   localparam logic [INSTR_W-1:0] NOP = 32'h5400_0000;

   logic               clock;
   logic               reset;
   logic               in_valid;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;
   logic               flush;
   logic               out_valid;
   logic [PC_W-1:0]    out_pc;
   logic [PC_W-1:0]    out_link;
   logic [INSTR_W-1:0] out_instr;
   logic               out_ready;
   logic [1:0]         count;

   fetch_buffer #(.DEPTH(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_link  (out_link),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic               iv;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               fl;
      logic               rdy;
      logic               e_ov;
      logic [PC_W-1:0]    e_pc;
      logic [INSTR_W-1:0] e_instr;
      logic [1:0]         e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_applied = 0;
   int   n_fail    = 0;

   function automatic logic [INSTR_W-1:0] iw(input logic [PC_W-1:0] pc);
      return {2'b10, pc};
   endfunction

   task automatic add(input logic iv, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr,
                      input logic fl, input logic rdy, input logic e_ov,
                      input logic [PC_W-1:0] e_pc, input logic [INSTR_W-1:0] e_instr,
                      input logic [1:0] e_cnt);
      vec_t v;
      v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.rdy = rdy;
      v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   task automatic idle(input logic rdy, input logic fl, input logic e_ov,
                       input logic [PC_W-1:0] e_pc, input logic [INSTR_W-1:0] e_instr,
                       input logic [1:0] e_cnt);
      add(1'b0, 'x, 'x, fl, rdy, e_ov, e_pc, e_instr, e_cnt);
   endtask

   // Link and ready are derived from the expected PC and occupancy: link = pc+1 (wrapping), ready = not full.
   task automatic check(input string name, input logic e_ov, input logic [PC_W-1:0] e_pc,
                        input logic [INSTR_W-1:0] e_instr, input logic [1:0] e_cnt);
      logic [PC_W-1:0] e_link;
      logic            e_ir;
      e_link = e_pc + 30'd1;
      e_ir   = (e_cnt != 2'd2);
      n_applied++;
      if (out_valid !== e_ov || out_pc !== e_pc || out_link !== e_link ||
          out_instr !== e_instr || in_ready !== e_ir || count !== e_cnt) begin
         n_fail++;
         $display("FAIL %s: got ov=%b pc=%h link=%h instr=%h ir=%b cnt=%0d, want ov=%b pc=%h link=%h instr=%h ir=%b cnt=%0d",
                  name, out_valid, out_pc, out_link, out_instr, in_ready, count,
                  e_ov, e_pc, e_link, e_instr, e_ir, e_cnt);
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // fill and drain; third push at full is ignored
      idle(0, 0, 0, 30'h0, NOP, 2'd0);
      add(1, 30'h10, 32'h2022_0005, 0, 0, 0, 30'h0, NOP, 2'd0);
      add(1, 30'h11, 32'h8C43_0004, 0, 0, 1, 30'h10, 32'h2022_0005, 2'd1);
      add(1, 30'h12, 32'hDEAD_BEEF, 0, 0, 1, 30'h10, 32'h2022_0005, 2'd2);
      idle(1, 0, 1, 30'h10, 32'h2022_0005, 2'd2);
      idle(1, 0, 1, 30'h11, 32'h8C43_0004, 2'd1);
      idle(0, 0, 0, 30'h11, NOP, 2'd0);
      // streaming 0x100..0x109 with push and pop every cycle
      add(1, 30'h100, iw(30'h100), 0, 1, 0, 30'h11, NOP, 2'd0);
      for (int k = 1; k < 10; k++) begin
         add(1, 30'h100 + 30'(k), iw(30'h100 + 30'(k)), 0, 1,
             1, 30'h100 + 30'(k - 1), iw(30'h100 + 30'(k - 1)), 2'd1);
      end
      idle(1, 0, 1, 30'h109, iw(30'h109), 2'd1);
      idle(0, 0, 0, 30'h109, NOP, 2'd0);
      // full with same-cycle pop: push still refused
      add(1, 30'h200, iw(30'h200), 0, 0, 0, 30'h109, NOP, 2'd0);
      add(1, 30'h201, iw(30'h201), 0, 0, 1, 30'h200, iw(30'h200), 2'd1);
      add(1, 30'h202, iw(30'h202), 0, 1, 1, 30'h200, iw(30'h200), 2'd2);
      idle(0, 0, 1, 30'h201, iw(30'h201), 2'd1);
      idle(1, 0, 1, 30'h201, iw(30'h201), 2'd1);
      idle(0, 0, 0, 30'h201, NOP, 2'd0);
      // flush beats push and pop; then flush while empty; then normal push after flush
      add(1, 30'h300, iw(30'h300), 0, 0, 0, 30'h201, NOP, 2'd0);
      add(1, 30'h301, iw(30'h301), 0, 0, 1, 30'h300, iw(30'h300), 2'd1);
      add(1, 30'h302, iw(30'h302), 1, 1, 1, 30'h300, iw(30'h300), 2'd2);
      idle(0, 0, 0, 30'h300, NOP, 2'd0);
      idle(0, 1, 0, 30'h300, NOP, 2'd0);
      add(1, 30'h303, iw(30'h303), 0, 0, 0, 30'h300, NOP, 2'd0);
      idle(1, 0, 1, 30'h303, iw(30'h303), 2'd1);
      idle(0, 0, 0, 30'h303, NOP, 2'd0);
      // PC wrap: link of all-ones is zero
      add(1, 30'h3FFF_FFFF, iw(30'h3FFF_FFFF), 0, 0, 0, 30'h303, NOP, 2'd0);
      idle(1, 0, 1, 30'h3FFF_FFFF, iw(30'h3FFF_FFFF), 2'd1);
      idle(0, 0, 0, 30'h3FFF_FFFF, NOP, 2'd0);

      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_held", 1'b0, 30'h0, NOP, 2'd0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         check($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_cnt);
         in_valid  = vecs[i].iv;
         in_pc     = vecs[i].pc;
         in_instr  = vecs[i].instr;
         flush     = vecs[i].fl;
         out_ready = vecs[i].rdy;
      end

      // asynchronous reset between edges while one entry is held
      @(negedge clock);
      in_valid  = 1'b1;
      in_pc     = 30'h400;
      in_instr  = iw(30'h400);
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      check("pre_async_rst", 1'b1, 30'h400, iw(30'h400), 2'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_now", 1'b0, 30'h0, NOP, 2'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("post_async_rst", 1'b0, 30'h0, NOP, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
